// File: rtl/ddr3_arbiter.sv
// Shares the single MIG user port between the framebuffer writer and the scanout reader.
// Reads win arbitration; a saturating deferral counter bounds how long a write can starve.
module ddr3_arbiter #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_DEFER  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data0,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_vld,
    output logic                  rd_data_end,
    output logic                  busy,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DATA_WIDTH-1:0] app_wdf_data,
    input  logic [DATA_WIDTH-1:0] app_rd_data,
    input  logic                  app_rd_data_valid,
    input  logic                  app_rd_data_end
);
    // state    | meaning
    // IDLE     | arbitrating between pending read and write requests
    // WR_DATA0 | pushing first write beat into the MIG write FIFO
    // WR_DATA1 | pushing second (last) write beat
    // WR_CMD   | issuing write command, wr_ack on acceptance
    // RD_CMD   | issuing read command, rd_ack on acceptance
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA0 = 3'd1,
        WR_DATA1 = 3'd2,
        WR_CMD   = 3'd3,
        RD_CMD   = 3'd4
    } state_t;

    localparam int                    CW        = $clog2(MAX_DEFER + 1);
    localparam logic [CW-1:0]         DEFER_MAX = CW'(MAX_DEFER);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(7);

    state_t                state, state_nxt;
    logic [CW-1:0]         defer_ctr, defer_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data0_q, data1_q;
    logic                  grant_wr, grant_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            defer_ctr <= '0;
        end else begin
            state     <= state_nxt;
            defer_ctr <= defer_nxt;
        end
    end

    // Burst address and both beats are frozen at grant so the requester may move on.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else if (grant_wr) begin
            addr_q  <= wr_addr & ADDR_MASK;
            data0_q <= wr_data0;
            data1_q <= wr_data1;
        end else if (grant_rd) begin
            addr_q  <= rd_addr & ADDR_MASK;
        end
    end

    always_comb begin
        state_nxt = state;
        defer_nxt = defer_ctr;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req && (!rd_req || defer_ctr == DEFER_MAX)) begin
                    grant_wr  = 1'b1;
                    defer_nxt = '0;
                    state_nxt = WR_DATA0;
                end else if (rd_req) begin
                    grant_rd  = 1'b1;
                    state_nxt = RD_CMD;
                    // only a read that beats a pending write counts as a deferral
                    if (wr_req)
                        defer_nxt = defer_ctr + CW'(1);
                end
            end
            WR_DATA0: if (app_wdf_rdy) state_nxt = WR_DATA1;
            WR_DATA1: if (app_wdf_rdy) state_nxt = WR_CMD;
            WR_CMD:   if (app_rdy)     state_nxt = IDLE;
            RD_CMD:   if (app_rdy)     state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Strobes are masked during reset so a dropped transaction never reaches MIG or the requester.
    always_comb begin
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        app_wdf_data = '0;
        wr_ack       = 1'b0;
        rd_ack       = 1'b0;
        case (state)
            WR_DATA0: begin
                app_wdf_wren = !rst;
                app_wdf_data = data0_q;
            end
            WR_DATA1: begin
                app_wdf_wren = !rst;
                app_wdf_end  = !rst;
                app_wdf_data = data1_q;
            end
            WR_CMD: begin
                app_en = !rst;
                wr_ack = app_rdy && !rst;
            end
            RD_CMD: begin
                app_en  = !rst;
                app_cmd = 3'b001;
                rd_ack  = app_rdy && !rst;
            end
            default: ;
        endcase
    end

    assign app_addr = addr_q;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
            rd_data_end <= 1'b0;
        end else begin
            rd_data     <= app_rd_data;
            rd_data_vld <= app_rd_data_valid;
            rd_data_end <= app_rd_data_end;
        end
    end

endmodule

// File: tb/tb_ddr3_arbiter.sv
// Directed and randomized bench for ddr3_arbiter against a transaction-level model
// of the arbitration rules, burst phases and read-return delay.
module tb_ddr3_arbiter;
    localparam int AW   = 19;
    localparam int DW   = 64;
    localparam int MAXD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req, rd_req, wr_ack, rd_ack;
    logic [AW-1:0] wr_addr, rd_addr, app_addr;
    logic [DW-1:0] wr_data0, wr_data1, rd_data, app_wdf_data, app_rd_data;
    logic          rd_data_vld, rd_data_end, busy;
    logic          app_rdy, app_wdf_rdy, app_en, app_wdf_wren, app_wdf_end;
    logic [2:0]    app_cmd;
    logic          app_rd_data_valid, app_rd_data_end;

    always #5 clk = ~clk;

    ddr3_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DEFER(MAXD)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_data_end(rd_data_end), .busy(busy),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_en(app_en), .app_cmd(app_cmd),
        .app_addr(app_addr), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model: kind 0 none, 1 write burst, 2 read; beats = write beats still to push
    int            m_kind, m_beats, m_ctr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_d0, m_d1, p_data;
    logic          p_vld, p_end;

    int            ack_wr_cyc, ack_rd_cyc, ack_n;
    logic [63:0]   ack_seq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic          e_en, e_wren, e_wend, e_wr_ack, e_rd_ack;
        logic [2:0]    e_cmd;
        logic [DW-1:0] e_wdata;
        #1;
        e_en = 0; e_wren = 0; e_wend = 0; e_wr_ack = 0; e_rd_ack = 0; e_cmd = 3'b000; e_wdata = '0;
        if (m_kind == 1 && m_beats > 0) begin
            e_wren  = !rst;
            e_wend  = (m_beats == 1) && !rst;
            e_wdata = (m_beats == 2) ? m_d0 : m_d1;
        end else if (m_kind == 1) begin
            e_en = !rst; e_cmd = 3'b000; e_wr_ack = app_rdy && !rst;
        end else if (m_kind == 2) begin
            e_en = !rst; e_cmd = 3'b001; e_rd_ack = app_rdy && !rst;
        end
        chk("busy", busy, m_kind != 0);
        chk("app_en", app_en, e_en);
        if (e_en) begin
            chk("app_cmd", app_cmd, e_cmd);
            chk("app_addr", app_addr, m_addr);
        end
        chk("wdf_wren", app_wdf_wren, e_wren);
        chk("wdf_end", app_wdf_end, e_wend);
        if (e_wren) chk("wdf_data", app_wdf_data, e_wdata);
        chk("wr_ack", wr_ack, e_wr_ack);
        chk("rd_ack", rd_ack, e_rd_ack);
        chk("rd_data", rd_data, p_data);
        chk("rd_vld", rd_data_vld, p_vld);
        chk("rd_end", rd_data_end, p_end);
        if (wr_ack === 1'b1) begin ack_wr_cyc = cyc; ack_seq = {ack_seq[62:0], 1'b1}; ack_n++; end
        if (rd_ack === 1'b1) begin ack_rd_cyc = cyc; ack_seq = {ack_seq[62:0], 1'b0}; ack_n++; end
        if (rst) begin
            m_kind = 0; m_ctr = 0; p_data = '0; p_vld = 0; p_end = 0;
        end else begin
            p_data = app_rd_data; p_vld = app_rd_data_valid; p_end = app_rd_data_end;
            if (m_kind == 0) begin
                if (wr_req && rd_req && m_ctr < MAXD) begin
                    m_kind = 2; m_addr = rd_addr & ~AW'(7); m_ctr = m_ctr + 1;
                end else if (wr_req) begin
                    m_kind = 1; m_beats = 2; m_addr = wr_addr & ~AW'(7);
                    m_d0 = wr_data0; m_d1 = wr_data1; m_ctr = 0;
                end else if (rd_req) begin
                    m_kind = 2; m_addr = rd_addr & ~AW'(7);
                end
            end else if (m_kind == 1 && m_beats > 0) begin
                if (app_wdf_rdy) m_beats = m_beats - 1;
            end else if (app_rdy) begin
                m_kind = 0;
            end
        end
        @(posedge clk); #1;
        cyc++;
        if (e_wr_ack) wr_req = 0;
        if (e_rd_ack) rd_req = 0;
    endtask

    initial begin
        int c0;
        logic [8:0] wp, ap;
        rst = 1; wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_data0 = '0; wr_data1 = '0;
        app_rdy = 1; app_wdf_rdy = 1; app_rd_data = '0; app_rd_data_valid = 0; app_rd_data_end = 0;
        m_kind = 0; m_beats = 0; m_ctr = 0; m_addr = '0; m_d0 = '0; m_d1 = '0;
        p_data = '0; p_vld = 0; p_end = 0; ack_wr_cyc = -1; ack_rd_cyc = -1; ack_n = 0; ack_seq = '0;
        repeat (2) @(posedge clk);
        #1; rst = 0; #1;
        chk("rst_busy", busy, 0);          chk("rst_app_en", app_en, 0);
        chk("rst_app_cmd", app_cmd, 0);    chk("rst_app_addr", app_addr, 0);
        chk("rst_wren", app_wdf_wren, 0);  chk("rst_wend", app_wdf_end, 0);
        chk("rst_wdata", app_wdf_data, 0); chk("rst_wr_ack", wr_ack, 0);
        chk("rst_rd_ack", rd_ack, 0);      chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_vld", rd_data_vld, 0); chk("rst_rd_end", rd_data_end, 0);
        cycle();

        // single write, inputs scrambled after grant
        wr_req = 1; wr_addr = AW'('h13); wr_data0 = 64'hA; wr_data1 = 64'hB; c0 = cyc;
        cycle();
        wr_addr = AW'($urandom); wr_data0 = {$urandom, $urandom}; wr_data1 = {$urandom, $urandom};
        repeat (4) cycle();
        chk("wr_ack_cycle", ack_wr_cyc - c0, 3);

        // back-pressure: wdf_rdy low 3 cycles in WR_DATA1, app_rdy low 2 in WR_CMD
        wp = 9'b111100011; ap = 9'b100111111;
        wr_req = 1; wr_addr = AW'('h2345); wr_data0 = 64'h1111; wr_data1 = 64'h2222; c0 = cyc;
        for (int i = 0; i < 9; i++) begin
            app_wdf_rdy = wp[i]; app_rdy = ap[i];
            cycle();
        end
        app_wdf_rdy = 1; app_rdy = 1;
        cycle();
        chk("bp_ack_cycle", ack_wr_cyc - c0, 8);

        // read command then two returned beats
        rd_req = 1; rd_addr = AW'('h100); c0 = cyc;
        repeat (2) cycle();
        chk("rd_ack_cycle", ack_rd_cyc - c0, 1);
        app_rd_data = 64'h11; app_rd_data_valid = 1; app_rd_data_end = 0;
        cycle();
        chk("rd_beat0", rd_data, 64'h11);
        app_rd_data = 64'h22; app_rd_data_end = 1;
        cycle();
        chk("rd_beat1", rd_data, 64'h22);
        chk("rd_beat1_end", rd_data_end, 1);
        app_rd_data = '0; app_rd_data_valid = 0; app_rd_data_end = 0;
        repeat (2) cycle();

        // starvation bound: both requesters always pending
        ack_n = 0; ack_seq = '0;
        for (int i = 0; i < 200 && ack_n < 10; i++) begin
            if (!rd_req) begin rd_req = 1; rd_addr = AW'($urandom); end
            if (!wr_req) begin
                wr_req = 1; wr_addr = AW'($urandom);
                wr_data0 = {$urandom, $urandom}; wr_data1 = {$urandom, $urandom};
            end
            cycle();
        end
        chk("starve_acks", ack_n, 10);
        chk("starve_seq", ack_seq, 64'b0000100001);
        rd_req = 0; wr_req = 0;
        repeat (6) cycle();

        // reset in WR_DATA1, held request re-granted afterwards
        wr_req = 1; wr_addr = AW'('h777); wr_data0 = 64'h5A; wr_data1 = 64'hA5; ack_wr_cyc = -1;
        repeat (2) cycle();
        rst = 1;
        cycle();
        rst = 0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_en", app_en, 0);
        chk("mid_rst_wren", app_wdf_wren, 0);
        chk("mid_rst_addr", app_addr, 0);
        chk("mid_rst_no_ack", ack_wr_cyc, -1);
        c0 = cyc;
        for (int i = 0; i < 10 && wr_req; i++) cycle();
        chk("regrant_ack_cycle", ack_wr_cyc - c0, 3);

        // randomized traffic with stalls, read returns and occasional reset
        for (int i = 0; i < 700; i++) begin
            app_rdy = ($urandom_range(0, 3) != 0);
            app_wdf_rdy = ($urandom_range(0, 3) != 0);
            app_rd_data = {$urandom, $urandom};
            app_rd_data_valid = $urandom_range(0, 1) == 1;
            app_rd_data_end = $urandom_range(0, 1) == 1;
            rst = ($urandom_range(0, 99) == 0);
            if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1; wr_addr = AW'($urandom);
                wr_data0 = {$urandom, $urandom}; wr_data1 = {$urandom, $urandom};
            end
            if (!rd_req && $urandom_range(0, 3) == 0) begin
                rd_req = 1; rd_addr = AW'($urandom);
            end
            cycle();
        end
        rst = 0; app_rdy = 1; app_wdf_rdy = 1; wr_req = 0; rd_req = 0;
        repeat (8) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
